// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store request/response bus between processor and data memory
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        ready;
    logic        rvalid;
    logic [31:0] rd;
    logic        err;

    modport master (
        output req, we, adr, wd,
        input  ready, rvalid, rd, err
    );

    modport slave (
        input  req, we, adr, wd,
        output ready, rvalid, rd, err
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated single-outstanding data-memory responder with done flag
module dmem_responder #(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] DONE_ADR    = 32'h64,
    parameter logic [31:0] DONE_DATA   = 32'd7
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus,
    output logic            done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_next;

    logic           lat_we;
    logic [31:0]    lat_adr;
    logic [31:0]    lat_wd;
    logic           err_q;
    logic [31:0]    rd_q;

    logic [31:0]    ram [DEPTH];

    logic           accept;
    logic           enter_resp;
    logic           commit;
    logic           cur_we;
    logic [31:0]    cur_adr;
    logic           cur_err;
    logic [AW-1:0]  cur_idx;
    logic [AW-1:0]  lat_idx;

    assign accept = (state == IDLE) && bus.req;

    // With no wait states the response is built straight from the bus on the accept edge.
    assign cur_we  = (state == IDLE) ? bus.we  : lat_we;
    assign cur_adr = (state == IDLE) ? bus.adr : lat_adr;
    assign cur_err = (cur_adr[1:0] != 2'b00) || ({2'b00, cur_adr[31:2]} >= 32'(DEPTH));
    assign cur_idx = cur_adr[AW+1:2];
    assign lat_idx = lat_adr[AW+1:2];

    assign enter_resp = (state_next == RESP);
    assign commit     = (state == RESP) && lat_we && !err_q;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
                    cnt_next   = '0;
                end
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            done    <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= '0;
            lat_we  <= 1'b0;
            lat_adr <= '0;
            lat_wd  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                lat_we  <= bus.we;
                lat_adr <= bus.adr;
                lat_wd  <= bus.wd;
            end
            if (enter_resp) begin
                err_q <= cur_err;
                rd_q  <= (!cur_we && !cur_err) ? ram[cur_idx] : '0;
            end
            if (commit && (lat_adr == DONE_ADR) && (lat_wd == DONE_DATA)) begin
                done <= 1'b1;
            end
        end
    end

    // Writes land as the response retires, so a reset during the request drops them.
    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            ram[lat_idx] <= lat_wd;
        end
    end

    assign bus.ready  = (state == IDLE) && !reset;
    assign bus.rvalid = (state == RESP) && !reset;
    assign bus.rd     = bus.rvalid ? rd_q : '0;
    assign bus.err    = bus.rvalid && err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder against a memory model
module tb_dmem_responder;
    localparam int DEPTH = 64;
    localparam int WAITC = 2;

    logic clk;
    logic reset;
    logic done;
    logic done0;

    int n_vec;
    int n_bad;

    logic [31:0] mem_m [DEPTH];
    bit          wr_m  [DEPTH];
    bit          done_m;

    dmem_responder_if bus ();
    dmem_responder_if bus0 ();

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .done  (done)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0),
        .done  (done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transaction on the wait-stated instance; called and returns at a negedge.
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d);
        int          n;
        int          idx;
        logic        e;
        logic [31:0] erd;
        e   = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
        idx = int'(a[7:2]);
        erd = (!w && !e) ? mem_m[idx] : 32'h0;
        bus.req = 1'b1;
        bus.we  = w;
        bus.adr = a;
        bus.wd  = d;
        n = 0;
        while (!bus.ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(bus.ready), 32'd1);
        @(negedge clk);
        bus.req = 1'b0;
        n = 0;
        while (!bus.rvalid && n < 20) begin
            check("busy_ready", 32'(bus.ready), 32'd0);
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(WAITC));
        check("resp_ready", 32'(bus.ready), 32'd0);
        check("resp_err", 32'(bus.err), 32'(e));
        if (w || e || wr_m[idx]) check("resp_rd", bus.rd, erd);
        if (w && !e) begin
            mem_m[idx] = d;
            wr_m[idx]  = 1'b1;
            if (a == 32'h64 && d == 32'd7) done_m = 1'b1;
        end
        @(negedge clk);
        check("rvalid_single", 32'(bus.rvalid), 32'd0);
        check("ready_back", 32'(bus.ready), 32'd1);
        check("done", 32'(done), 32'(done_m));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        logic [31:0] wd0 [4];
        logic [31:0] q [$];
        logic [31:0] e;
        bit          issued;
        int          i;
        int          cyc;

        n_vec  = 0;
        n_bad  = 0;
        done_m = 1'b0;
        for (int k = 0; k < DEPTH; k++) wr_m[k] = 1'b0;
        reset    = 1'b1;
        bus.req  = 1'b1;
        bus.we   = 1'b1;
        bus.adr  = 32'h64;
        bus.wd   = 32'd7;
        bus0.req = 1'b0;
        bus0.we  = 1'b0;
        bus0.adr = 32'h0;
        bus0.wd  = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("rst_rd", bus.rd, 32'h0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset   = 1'b0;
        bus.req = 1'b0;
        @(negedge clk);
        check("no_accept_in_reset", 32'(bus.ready), 32'd1);
        check("no_rvalid_after_reset", 32'(bus.rvalid), 32'd0);

        xact(1'b1, 32'h64, 32'd7);
        xact(1'b0, 32'h64, 32'h0);
        xact(1'b1, 32'h66, 32'hFF);
        xact(1'b0, 32'h64, 32'h0);
        xact(1'b0, 32'h100, 32'h0);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(3))
                0: a = 32'($urandom_range(DEPTH - 1)) << 2;
                1: a = (32'($urandom_range(DEPTH - 1)) << 2) + 32'($urandom_range(3, 1));
                2: a = ($urandom | 32'h100) & 32'hFFFF_FFFC;
                default: a = 32'h64;
            endcase
            w = 1'($urandom_range(1));
            d = $urandom_range(1) ? 32'd7 : $urandom;
            xact(w, a, d);
        end

        xact(1'b1, 32'h10, 32'h1234);
        bus.req = 1'b1;
        bus.we  = 1'b1;
        bus.adr = 32'h10;
        bus.wd  = 32'hDEAD;
        @(negedge clk);
        bus.req = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 32'(bus.ready), 32'd0);
        check("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
        reset  = 1'b0;
        done_m = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("dropped_rvalid", 32'(bus.rvalid), 32'd0);
        end
        check("done_cleared", 32'(done), 32'd0);
        xact(1'b0, 32'h10, 32'h0);

        for (int k = 0; k < 4; k++) wd0[k] = $urandom;
        i = 0;
        issued = 1'b0;
        for (cyc = 0; cyc < 40 && (i < 8 || q.size() > 0); cyc++) begin
            check("w0_rvalid", 32'(bus0.rvalid), 32'(issued));
            check("w0_ready", 32'(bus0.ready), 32'(!bus0.rvalid));
            if (bus0.rvalid && q.size() > 0) begin
                e = q.pop_front();
                check("w0_rd", bus0.rd, e);
                check("w0_err", 32'(bus0.err), 32'd0);
            end
            issued = 1'b0;
            if (bus0.ready && i < 8) begin
                bus0.req = 1'b1;
                bus0.we  = (i < 4);
                bus0.adr = 32'h20 + 32'((i % 4) * 4);
                bus0.wd  = (i < 4) ? wd0[i] : 32'h0;
                q.push_back((i < 4) ? 32'h0 : wd0[i - 4]);
                issued = 1'b1;
                i++;
            end
            @(negedge clk);
        end
        bus0.req = 1'b0;
        check("w0_cycles", 32'(cyc), 32'd16);
        check("w0_drained", 32'(q.size()), 32'd0);
        check("w0_done", 32'(done0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
